// File: rtl/difftest_commit_queue_pkg.sv
// rtl/difftest_commit_queue_pkg.sv - shared widths and pointer-size helper for the commit queue
package difftest_commit_queue_pkg;

    localparam int DIFF_DATA_WIDTH = 32;
    localparam int DIFF_SEQ_WIDTH  = 64;
    localparam int DIFF_DEPTH      = 4;

    // Pointer carries one extra wrap bit beyond the index so full and empty differ.
    function automatic int ptr_bits(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/diff_fifo.sv
// rtl/diff_fifo.sv - generic synchronous FIFO with wrap-bit pointers
module diff_fifo
    import difftest_commit_queue_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [ptr_bits(DEPTH)-1:0] count_o
);

    localparam int CW = ptr_bits(DEPTH);
    localparam int AW = CW - 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign full_o  = (count_o == CW'(DEPTH));
    assign empty_o = (count_o == '0);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // A pop frees the slot a same-cycle push into a full FIFO needs.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/difftest_commit_queue.sv
// rtl/difftest_commit_queue.sv - sequence-tagged commit record queue with stall and overflow reporting
module difftest_commit_queue
    import difftest_commit_queue_pkg::*;
#(
    parameter int DATA_WIDTH = DIFF_DATA_WIDTH,
    parameter int DEPTH      = DIFF_DEPTH,
    parameter int SEQ_WIDTH  = DIFF_SEQ_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       diffen,
    input  logic [DATA_WIDTH-1:0]      diffPC,
    input  logic [DATA_WIDTH-1:0]      diffInstr,
    input  logic [DATA_WIDTH-1:0]      nextPC,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_pc,
    output logic [DATA_WIDTH-1:0]      out_instr,
    output logic [DATA_WIDTH-1:0]      out_next_pc,
    output logic [SEQ_WIDTH-1:0]       out_seq,
    output logic                       commit_stall,
    output logic                       overflow,
    output logic [SEQ_WIDTH-1:0]       commit_cnt,
    output logic [ptr_bits(DEPTH)-1:0] occupancy
);

    localparam int CW = ptr_bits(DEPTH);
    localparam int RW = 3 * DATA_WIDTH + SEQ_WIDTH;

    logic [SEQ_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 full, empty, pop, push_ok;
    logic [RW-1:0]        wdata, rdata;

    assign pop     = out_valid && out_ready;
    assign push_ok = diffen && (!full || pop);
    assign wdata   = {diffPC, diffInstr, nextPC, cnt_q};

    assign cnt_d = push_ok ? cnt_q + 1'b1 : cnt_q;
    assign ovf_d = ovf_q || (diffen && full && !pop);

    diff_fifo #(
        .WIDTH (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_ok),
        .pop_i   (pop),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty),
        .count_o (occupancy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign out_valid    = !empty;
    assign commit_stall = (occupancy >= CW'(DEPTH - 1));
    assign overflow     = ovf_q;
    assign commit_cnt   = cnt_q;

    // Idle outputs read as zero rather than stale storage contents.
    assign {out_pc, out_instr, out_next_pc, out_seq} = out_valid ? rdata : '0;

endmodule

// File: doc/difftest_commit_queue.md
# difftest_commit_queue

Commit-record buffer directly downstream of the Difftest stage. Captures each retired-instruction record (PC, instruction word, next PC) on `diffen`, tags it with a sequence number, and holds it in a small FIFO. The simulator-side DPI consumer drains records through a valid/ready handshake. The block raises a stall request before it can lose a record and flags any loss that does occur.

## Interface
Parameters:
- `DATA_WIDTH`, default `` `DATA_WIDTH `` (32): width of PC, instruction and next-PC fields.
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `SEQ_WIDTH`, default 64: width of the sequence number and commit counter.

Ports (clock and reset first):
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `diffen`  in  1  commit strobe from Difftest; one record per high cycle.
- `diffPC`  in  DATA_WIDTH  PC of the committing instruction.
- `diffInstr`  in  DATA_WIDTH  instruction word.
- `nextPC`  in  DATA_WIDTH  PC after the commit.
- `out_valid`  out  1  head record available.
- `out_ready`  in  1  consumer accepts the head record.
- `out_pc`, `out_instr`, `out_next_pc`  out  DATA_WIDTH  head record fields.
- `out_seq`  out  SEQ_WIDTH  sequence number of the head record.
- `commit_stall`  out  1  pipeline hold request.
- `overflow`  out  1  sticky; a record was dropped.
- `commit_cnt`  out  SEQ_WIDTH  total records accepted.
- `occupancy`  out  log2(DEPTH)+1  current entry count.

## Operation
- Push: `diffen`=1 and not (full and no pop this cycle). The entry written is {diffPC, diffInstr, nextPC, commit_cnt}. `commit_cnt` increments by 1 after each push and wraps modulo 2^SEQ_WIDTH.
- Pop: `out_valid`=1 and `out_ready`=1. The head pointer advances.
- Full is `occupancy`==DEPTH. Empty is `occupancy`==0.
- Pointers are log2(DEPTH)+1 bits; the MSB distinguishes full from empty on wrap-around.
- Push while full with a simultaneous pop: both take effect and occupancy is unchanged.
- Push while full without a pop: the record is dropped, `overflow` sets and stays set until reset, and `commit_cnt` is not incremented.
- Pop while empty: ignored; `out_valid` is 0.
- `commit_stall` = `occupancy` ≥ DEPTH-1, so the pipeline is held one entry early and one in-flight commit still fits.
- While `out_valid`=0, `out_pc`, `out_instr`, `out_next_pc` and `out_seq` are driven 0, matching Difftest's zeroed idle outputs.
- Asserting `rst_n` mid-operation discards all entries.

## Timing
- Reset values: `out_valid`=0, data outputs 0, `commit_stall`=0, `overflow`=0, `commit_cnt`=0, `occupancy`=0; pointers reset to 0.
- Latency: a record pushed at edge N appears on `out_*` with `out_valid`=1 after edge N (no same-cycle fall-through).
- Output data comes from the storage array indexed by the head pointer. It is stable while `out_valid`=1 and `out_ready`=0.
- `commit_stall` and `occupancy` reflect registered state and are updated one edge after the push or pop that changes them.
- `overflow` sets at the edge of the dropped push.
- Throughput: one push and one pop per cycle sustained.

## Structure
- The record field widths, `SEQ_WIDTH` default and DEPTH log2 helper live in the shared `define.v` header, under the same `DIFFTEST` guard.
- The whole block is compiled only under `` `ifdef DIFFTEST ``.
- Use one sub-module, `diff_fifo`: a generic synchronous FIFO with width and depth parameters and push/pop/full/empty/count ports.
- The top level adds sequence tagging, stall threshold, overflow sticky bit and output zeroing.

## Test plan
- After reset, with no `diffen` for 10 cycles: all outputs stay 0 and `out_valid`=0.
- Single commit of PC=0x80000000, instr=0x00000413, next=0x80000004, `out_ready`=0: one cycle later `out_valid`=1 with those fields and `out_seq`=0; `commit_cnt`=1; holding `out_ready` low keeps the data stable.
- Four back-to-back commits with `out_ready`=0 (DEPTH=4): `commit_stall` goes to 1 when occupancy reaches 3; `occupancy`=4; draining yields `out_seq` 0,1,2,3 in order.
- Fifth commit while full with `out_ready`=0: `overflow`=1 permanently, `commit_cnt` stays 4, the FIFO contents are unchanged.
- Full FIFO, commit and pop in the same cycle: occupancy stays 4, no overflow, new record gets `out_seq`=4; pointers wrap correctly over 12 more cycles of continuous push and pop.
- `rst_n` pulsed low asynchronously with 3 entries held: outputs clear immediately, `occupancy`=0, and the next commit gets `out_seq`=0.
